pipe_control: RTL and testbench

- Hazard and exception controller for the five-stage Y86-64 pipeline.
- Watches the fetch/decode/execute/memory/writeback pipeline-register fields and generates the stall and bubble controls for each pipeline register.
- Sequences the processor from running, through draining on an exception, to a stopped state, and latches the terminating status.
- Keeps per-run cycle, stall and bubble statistics.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/pipe_control_if.sv | 39 +++
 rtl/pipe_control_sat_counter.sv | 38 +++
 rtl/pipe_control.sv | 132 +++++++++++++
 tb/tb_pipe_control.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, icodes, register IDs and the pipeline controller state type.
// The helper identifies instructions whose destination is written from memory.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        STOPPED = 2'd2
    } ctl_state_t;

    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_control_if.sv
// Pipeline-register fields seen by the hazard controller and the controls/status it returns.
// master = datapath side, slave = controller side.
interface pipe_control_if #(parameter int CNT_W = 32);

    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;
    logic [3:0]       halt_stat;
    logic [CNT_W-1:0] cyc_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  halted, halt_stat, cyc_count, stall_count, bubble_count
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output halted, halt_stat, cyc_count, stall_count, bubble_count
    );

endinterface

// File: rtl/pipe_control_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
// With PIPE_PERF_CNT_EN undefined no flops are built and the output is tied to zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

`ifdef PIPE_PERF_CNT_EN
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, en_i};
    assign cnt_o     = '0;
`endif

endmodule

// File: rtl/pipe_control.sv
// Y86-64 hazard/exception controller: stall and bubble controls, RUN->DRAIN->STOPPED sequencing,
// terminating status capture and performance counters (counters built only with PIPE_PERF_CNT_EN).
module pipe_control
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    pipe_control_if.slave pc
);

    logic load_use;
    logic ret_pend;
    logic mispred;
    logic exc_m;
    logic exc_w;

    assign load_use = is_mem_load(pc.E_icode) && (pc.E_dstM != REG_NONE) &&
                      ((pc.E_dstM == pc.d_srcA) || (pc.E_dstM == pc.d_srcB));
    assign ret_pend = (pc.D_icode == I_RET) || (pc.E_icode == I_RET) || (pc.M_icode == I_RET);
    assign mispred  = (pc.E_icode == I_JXX) && !pc.e_Cnd;
    assign exc_m    = (pc.m_stat != STAT_AOK);
    assign exc_w    = (pc.W_stat != STAT_AOK);

    ctl_state_t state_q;
    logic       halted_q;
    logic [3:0] halt_stat_q;

    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        if (rst) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else if (state_q == STOPPED) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
            w_stall  = 1'b1;
        end else begin
            f_stall  = load_use | ret_pend;
            d_stall  = load_use;
            d_bubble = mispred | (ret_pend & ~load_use);
            e_bubble = mispred | load_use;
            m_bubble = exc_m | exc_w;
            w_stall  = exc_w;
        end
    end

    // When both stages fault in RUN, the writeback instruction is older, so it terminates the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            halt_stat_q <= STAT_AOK;
        end else begin
            case (state_q)
                RUN: begin
                    if (exc_w) begin
                        state_q     <= STOPPED;
                        halted_q    <= 1'b1;
                        halt_stat_q <= pc.W_stat;
                    end else if (exc_m) begin
                        state_q     <= DRAIN;
                        halt_stat_q <= pc.m_stat;
                    end
                end
                DRAIN: begin
                    if (exc_w) begin
                        state_q  <= STOPPED;
                        halted_q <= 1'b1;
                    end
                end
                STOPPED: begin
                    state_q <= STOPPED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc.F_stall   = f_stall;
    assign pc.D_stall   = d_stall;
    assign pc.D_bubble  = d_bubble;
    assign pc.E_bubble  = e_bubble;
    assign pc.M_bubble  = m_bubble;
    assign pc.W_stall   = w_stall;
    assign pc.halted    = halted_q;
    assign pc.halt_stat = halt_stat_q;

    logic running;
    assign running = (state_q != STOPPED);

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (running),
        .cnt_o (pc.cyc_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (running & d_stall),
        .cnt_o (pc.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (running & (d_bubble | e_bubble)),
        .cnt_o (pc.bubble_count)
    );

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: directed hazard/exception/reset cases then randomized episodes,
// checked against a flag-based reference model of the controller.
module tb_pipe_control;
    import y86_pkg::*;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_control_if #(.CNT_W(CW)) pif ();

    pipe_control #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .pc  (pif)
    );

    typedef struct packed {
        logic          f_stall;
        logic          d_stall;
        logic          d_bubble;
        logic          e_bubble;
        logic          m_bubble;
        logic          w_stall;
        logic          halted;
        logic [3:0]    hs;
        logic [CW-1:0] cyc;
        logic [CW-1:0] stl;
        logic [CW-1:0] bub;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "stopped" and "status already captured" flags plus plain integer counts.
    bit         m_stopped;
    bit         m_captured;
    logic [3:0] m_hs;
    int         m_cyc;
    int         m_stl;
    int         m_bub;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("F_stall",      32'(pif.F_stall),      32'(e.f_stall));
            chk("D_stall",      32'(pif.D_stall),      32'(e.d_stall));
            chk("D_bubble",     32'(pif.D_bubble),     32'(e.d_bubble));
            chk("E_bubble",     32'(pif.E_bubble),     32'(e.e_bubble));
            chk("M_bubble",     32'(pif.M_bubble),     32'(e.m_bubble));
            chk("W_stall",      32'(pif.W_stall),      32'(e.w_stall));
            chk("halted",       32'(pif.halted),       32'(e.halted));
            chk("halt_stat",    32'(pif.halt_stat),    32'(e.hs));
            chk("cyc_count",    32'(pif.cyc_count),    32'(e.cyc));
            chk("stall_count",  32'(pif.stall_count),  32'(e.stl));
            chk("bubble_count", 32'(pif.bubble_count), 32'(e.bub));
        end
    end

    function automatic void rules(output bit fs, output bit ds, output bit db,
                                  output bit eb, output bit mb, output bit ws);
        bit ld_dst_read, ret_in_flight, wrong_path;
        ld_dst_read   = (pif.E_icode == 4'h5 || pif.E_icode == 4'hB) && pif.E_dstM != 4'hF &&
                        (pif.E_dstM == pif.d_srcA || pif.E_dstM == pif.d_srcB);
        ret_in_flight = (pif.D_icode == 4'h9) || (pif.E_icode == 4'h9) || (pif.M_icode == 4'h9);
        wrong_path    = (pif.E_icode == 4'h7) && !pif.e_Cnd;
        fs = ld_dst_read || ret_in_flight;
        ds = ld_dst_read;
        db = wrong_path || (ret_in_flight && !ld_dst_read);
        eb = wrong_path || ld_dst_read;
        mb = (pif.m_stat != 4'b1000) || (pif.W_stat != 4'b1000);
        ws = (pif.W_stat != 4'b1000);
    endfunction

    function automatic logic [CW-1:0] cnt_view(input int v);
`ifdef PIPE_PERF_CNT_EN
        return CW'(v);
`else
        return (v < 0) ? {CW{1'b1}} : '0;
`endif
    endfunction

    function automatic exp_t expect_now(input bit in_rst);
        exp_t e;
        bit fs, ds, db, eb, mb, ws;
        rules(fs, ds, db, eb, mb, ws);
        e.halted = m_stopped;
        e.hs     = m_hs;
        e.cyc    = cnt_view(m_cyc);
        e.stl    = cnt_view(m_stl);
        e.bub    = cnt_view(m_bub);
        if (in_rst) begin
            {e.f_stall, e.d_stall, e.d_bubble, e.e_bubble, e.m_bubble, e.w_stall} = 6'b101110;
        end else if (m_stopped) begin
            {e.f_stall, e.d_stall, e.d_bubble, e.e_bubble, e.m_bubble, e.w_stall} = 6'b110111;
        end else begin
            {e.f_stall, e.d_stall, e.d_bubble, e.e_bubble, e.m_bubble, e.w_stall} =
                {fs, ds, db, eb, mb, ws};
        end
        return e;
    endfunction

    task automatic model_reset();
        m_stopped  = 1'b0;
        m_captured = 1'b0;
        m_hs       = 4'b1000;
        m_cyc      = 0;
        m_stl      = 0;
        m_bub      = 0;
    endtask

    task automatic model_edge();
        bit fs, ds, db, eb, mb, ws;
        bit em, ew;
        if (!m_stopped) begin
            rules(fs, ds, db, eb, mb, ws);
            m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
            if (ds) m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
            if (db || eb) m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
            em = (pif.m_stat != 4'b1000);
            ew = (pif.W_stat != 4'b1000);
            if (!m_captured && (em || ew)) begin
                m_captured = 1'b1;
                m_hs       = ew ? pif.W_stat : pif.m_stat;
            end
            if (ew) m_stopped = 1'b1;
        end
    endtask

    task automatic set_in(input logic [3:0] dic, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] eic, input logic [3:0] dm, input logic cnd,
                          input logic [3:0] mic, input logic [3:0] ms, input logic [3:0] ws);
        pif.D_icode = dic;
        pif.d_srcA  = sa;
        pif.d_srcB  = sb;
        pif.E_icode = eic;
        pif.E_dstM  = dm;
        pif.e_Cnd   = cnd;
        pif.M_icode = mic;
        pif.m_stat  = ms;
        pif.W_stat  = ws;
    endtask

    task automatic idle();
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'b1000, 4'b1000);
    endtask

    // Entered at posedge+1; one expectation per cycle, checked at the following negedge.
    task automatic step();
        sbq.push_back(expect_now(1'b0));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rst_step();
        #2 rst = 1'b1;
        model_reset();
        sbq.push_back(expect_now(1'b1));
        #3 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [3:0] ic_tab[7];
    logic [3:0] rg_tab[4];
    logic [3:0] st_tab[3];

    task automatic rand_in(input int exc_m_odds, input int exc_w_odds);
        logic [3:0] ms, ws;
        ms = (exc_m_odds > 0 && $urandom_range(0, exc_m_odds - 1) == 0) ?
             st_tab[$urandom_range(0, 2)] : 4'b1000;
        ws = (exc_w_odds > 0 && $urandom_range(0, exc_w_odds - 1) == 0) ?
             st_tab[$urandom_range(0, 2)] : 4'b1000;
        set_in(ic_tab[$urandom_range(0, 6)], rg_tab[$urandom_range(0, 3)],
               rg_tab[$urandom_range(0, 3)], ic_tab[$urandom_range(0, 6)],
               rg_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
               ic_tab[$urandom_range(0, 6)], ms, ws);
    endtask

    initial begin
        ic_tab = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
        rg_tab = '{4'h3, 4'h4, 4'hF, 4'h0};
        st_tab = '{4'b0100, 4'b0010, 4'b0001};

        rst = 1'b1;
        idle();
        model_reset();
        #1;
        sbq.push_back(expect_now(1'b1));
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        set_in(I_OPQ, 4'h3, 4'hF, I_MRMOVQ, 4'h3, 1'b1, I_NOP, STAT_AOK, STAT_AOK);
        step();
        idle(); step();
        set_in(I_NOP, 4'hF, 4'hF, I_JXX, 4'hF, 1'b0, I_NOP, STAT_AOK, STAT_AOK);
        step();
        set_in(I_NOP, 4'hF, 4'hF, I_JXX, 4'hF, 1'b1, I_NOP, STAT_AOK, STAT_AOK);
        step();
        set_in(I_RET, 4'hF, 4'hF, I_NOP, 4'hF, 1'b1, I_NOP, STAT_AOK, STAT_AOK); step();
        set_in(I_NOP, 4'hF, 4'hF, I_RET, 4'hF, 1'b1, I_NOP, STAT_AOK, STAT_AOK); step();
        set_in(I_NOP, 4'hF, 4'hF, I_NOP, 4'hF, 1'b1, I_RET, STAT_AOK, STAT_AOK); step();
        idle(); step();
        set_in(I_RET, 4'hF, 4'h4, I_POPQ, 4'h4, 1'b1, I_NOP, STAT_AOK, STAT_AOK);
        step();
        set_in(I_NOP, 4'hF, 4'hF, I_JXX, 4'hF, 1'b0, I_RET, STAT_AOK, STAT_AOK);
        step();

        idle(); pif.m_stat = STAT_ADR; step();
        idle(); pif.W_stat = STAT_ADR; step();
        idle(); step();
        idle(); pif.m_stat = STAT_INS; step();
        idle(); pif.W_stat = STAT_HLT; step();
        idle(); rst_step();
        idle(); step();
        step();

        for (int i = 0; i < 80; i++) begin
            rand_in(0, 0);
            step();
        end
        idle(); rst_step();

        for (int ep = 0; ep < 10; ep++) begin
            int len;
            len = $urandom_range(20, 90);
            for (int i = 0; i < len; i++) begin
                rand_in(25, 40);
                step();
            end
            rand_in(25, 40);
            rst_step();
        end

        idle(); step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
